imem_ctrl: RTL
==============

# imem_ctrl

Controller for the single-port, word-indexed instruction memory. After reset it owns the memory port in LOAD mode and streams a boot image into consecutive words. It then switches to RUN mode, where it serves core instruction fetches with one-cycle registered latency and bounds/alignment checking. It sits between the boot source, the core fetch stage and the instruction memory (`en`, `A`, `RD` plus a write port), and releases the core via `core_run`.

## Interface
- `DATA_WIDTH`, 32, instruction/word width
- `MEM_CAPACITY`, 10, memory depth in words
- `CNT_WIDTH`, 8, width of word pointers/counters (must satisfy 2^CNT_WIDTH > MEM_CAPACITY)

- `clk`  in  1  clock, rising edge
- `rstn`  in  1  reset, asynchronous, active-low
- `boot_valid`  in  1  boot word present
- `boot_data`  in  DATA_WIDTH  boot word
- `boot_last`  in  1  marks final boot word
- `boot_ready`  out  1  controller accepts a boot word
- `reload`  in  1  single-cycle pulse: return to LOAD
- `fetch_req`  in  1  fetch request, one per cycle max
- `fetch_addr`  in  DATA_WIDTH  byte address (PC)
- `fetch_valid`  out  1  response strobe, one cycle
- `fetch_instr`  out  DATA_WIDTH  fetched instruction
- `fetch_err`  out  1  fetch faulted (qualified by fetch_valid)
- `core_run`  out  1  image loaded, core may fetch
- `load_count`  out  CNT_WIDTH  number of valid words loaded
- `mem_en`  out  1  memory enable
- `mem_we`  out  1  memory write enable
- `mem_addr`  out  DATA_WIDTH  word index
- `mem_wdata`  out  DATA_WIDTH  write data
- `mem_rdata`  in  DATA_WIDTH  combinational read data

## Operation
- States: LOAD, RUN. Reset enters LOAD.
- LOAD:
  - `boot_ready`=1; `core_run`=0.
  - `mem_en`=1. `mem_we`=`boot_valid`. `mem_addr`=wptr. `mem_wdata`=`boot_data`.
  - On accept (`boot_valid`&&`boot_ready`): wptr++, `load_count`=wptr+1.
  - Go to RUN if the accepted word has `boot_last`=1 or wptr==MEM_CAPACITY-1; excess boot words are never accepted.
  - `fetch_req` is ignored: no `fetch_valid` is produced.
- RUN:
  - `boot_ready`=0; `core_run`=1; `mem_we`=0.
  - `mem_en`=`fetch_req`. `mem_addr`=`fetch_addr`>>2, zero-extended.
  - Fault if `fetch_addr[1:0]`!=0, or word index >= `load_count`.
  - On fault: `fetch_err`=1 and `fetch_instr`=32'h00000013 (NOP). Otherwise `fetch_err`=0 and `fetch_instr`=`mem_rdata`.
- `reload` in RUN: next state LOAD, wptr=0, `load_count`=0. A `fetch_req` in the same cycle is dropped (no response). `reload` in LOAD is ignored.
- Reset mid-load: the load is aborted, all counters are cleared, and memory contents are not touched by the controller.

## Timing
- Reset values:
  - state LOAD, wptr 0, `load_count` 0
  - `fetch_valid` 0, `fetch_instr` 0, `fetch_err` 0
  - `core_run` 0, `boot_ready` 1 (LOAD)
- Boot write: data is written at the rising edge of the accept cycle. The RUN transition is effective the cycle after the final accept; `core_run` rises then.
- Fetch: request in cycle N gives `fetch_valid`=1 with `fetch_instr`/`fetch_err` registered in cycle N+1. Back-to-back requests give one response per cycle, in order.
- `fetch_instr`/`fetch_err` hold their value when `fetch_valid`=0.
- `mem_*` outputs are combinational from state, wptr and the fetch inputs. All other outputs are registered.

## Test plan
- Reset, boot 4 words FFC4A303, 0064A423, 0062E233, FE420AE3 with `boot_last` on the 4th -> `load_count`=4, `core_run`=1 one cycle after the last accept, `boot_ready`=0.
- Fetch addresses 0, 4, 8, 12 back-to-back -> four consecutive `fetch_valid` cycles returning the four words in order, `fetch_err`=0.
- Fetch 16 (index 4 >= `load_count`) and fetch 6 (misaligned) -> `fetch_err`=1, `fetch_instr`=00000013.
- Boot 12 words without `boot_last` -> exactly 10 accepted, RUN entered after the 10th, `boot_ready`=0 for words 11-12, `load_count`=10.
- `reload` asserted together with `fetch_req`@0 -> no `fetch_valid`, `core_run` falls next cycle, `load_count`=0; reboot 1 word then fetch 0 returns the new word.
- `rstn` low after 2 of 4 boot words -> all outputs at reset values; reboot completes normally; `fetch_req` during LOAD never produces `fetch_valid`.

Source files
------------

// File: rtl/imem_ctrl.sv
// imem_ctrl: instruction memory controller.
//
// After reset the controller owns the memory port in LOAD mode and writes
// incoming boot words into consecutive memory words. The load ends on the
// word marked boot_last, or when the memory is full. The controller then
// enters RUN mode. In RUN mode it serves core fetches with one cycle of
// registered latency, and it faults misaligned fetches and fetches beyond
// the loaded image.
//
// Ports:
//   clk, rstn                         clock, async active-low reset
//   boot_valid/boot_data/boot_last    boot word stream in
//   boot_ready                        boot word accepted (LOAD only)
//   reload                            pulse: return from RUN to LOAD
//   fetch_req/fetch_addr              core fetch request (byte address)
//   fetch_valid/fetch_instr/fetch_err fetch response, registered
//   core_run                          image loaded, core may run
//   load_count                        number of words loaded
//   mem_en/mem_we/mem_addr/mem_wdata  memory port (combinational)
//   mem_rdata                         memory read data (combinational)
//
// state | meaning
// ------+---------------------------------------------------------
// LOAD  | memory owned by the boot stream, core held off
// RUN   | image loaded, serving core fetches

module imem_ctrl #(
    parameter int DATA_WIDTH   = 32,
    parameter int MEM_CAPACITY = 10,
    parameter int CNT_WIDTH    = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  boot_valid,
    input  logic [DATA_WIDTH-1:0] boot_data,
    input  logic                  boot_last,
    output logic                  boot_ready,
    input  logic                  reload,
    input  logic                  fetch_req,
    input  logic [DATA_WIDTH-1:0] fetch_addr,
    output logic                  fetch_valid,
    output logic [DATA_WIDTH-1:0] fetch_instr,
    output logic                  fetch_err,
    output logic                  core_run,
    output logic [CNT_WIDTH-1:0]  load_count,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [DATA_WIDTH-1:0] NOP_INSTR = DATA_WIDTH'(32'h0000_0013);
    localparam logic [CNT_WIDTH-1:0]  LAST_IDX  = CNT_WIDTH'(MEM_CAPACITY - 1);

    state_t                 state, state_nxt;
    logic [CNT_WIDTH-1:0]   wptr, wptr_nxt;
    logic [CNT_WIDTH-1:0]   load_count_nxt;
    logic [DATA_WIDTH-1:0]  fetch_idx;
    logic                   fetch_fault;
    logic                   fetch_take;

    assign fetch_idx   = fetch_addr >> 2;
    assign fetch_fault = (fetch_addr[1:0] != 2'b00) ||
                         (fetch_idx >= DATA_WIDTH'(load_count));
    // A fetch in the same cycle as reload is dropped: the image is about to be replaced.
    assign fetch_take  = (state == RUN) && fetch_req && !reload;

    always_comb begin
        state_nxt      = state;
        wptr_nxt       = wptr;
        load_count_nxt = load_count;
        mem_en         = 1'b0;
        mem_we         = 1'b0;
        mem_addr       = '0;
        mem_wdata      = '0;
        case (state)
            LOAD: begin
                mem_en    = 1'b1;
                mem_we    = boot_valid;
                mem_addr  = DATA_WIDTH'(wptr);
                mem_wdata = boot_data;
                // boot_ready is always high in LOAD, so boot_valid alone is the accept.
                if (boot_valid) begin
                    wptr_nxt       = wptr + 1'b1;
                    load_count_nxt = wptr + 1'b1;
                    if (boot_last || (wptr == LAST_IDX)) begin
                        state_nxt = RUN;
                    end
                end
            end
            RUN: begin
                mem_en   = fetch_req;
                mem_addr = fetch_idx;
                if (reload) begin
                    state_nxt      = LOAD;
                    wptr_nxt       = '0;
                    load_count_nxt = '0;
                end
            end
            default: begin
                state_nxt = LOAD;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= LOAD;
            wptr        <= '0;
            load_count  <= '0;
            boot_ready  <= 1'b1;
            core_run    <= 1'b0;
            fetch_valid <= 1'b0;
            fetch_instr <= '0;
            fetch_err   <= 1'b0;
        end else begin
            state       <= state_nxt;
            wptr        <= wptr_nxt;
            load_count  <= load_count_nxt;
            boot_ready  <= (state_nxt == LOAD);
            core_run    <= (state_nxt == RUN);
            fetch_valid <= fetch_take;
            if (fetch_take) begin
                fetch_err   <= fetch_fault;
                fetch_instr <= fetch_fault ? NOP_INSTR : mem_rdata;
            end
        end
    end

endmodule
